clk_div_multi: RTL and testbench

- Multi-channel programmable clock-enable/divider generator; successor to the fixed single-output divider.
- Each channel produces a 50%-duty divided square wave (clk_out) and a one-cycle terminal-count strobe (tick), all synchronous to clk.
- Divisors are reloadable at runtime through a valid/ready load port.
- Loads are applied glitch-free at each channel's next terminal count.
- Feeds LED/display refresh and slow-FSM timing in the lab top levels.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 87 ++++++++
 rtl/clk_div_multi.sv | 72 +++++++
 tb/tb_clk_div_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_CNT_W        = 32;
  localparam int unsigned CLK_DIV_DEFAULT_HALF = 150000000;
  // Wide enough to hold any channel index up to and including NUM_CH = 16.
  localparam int unsigned CLK_DIV_CH_IDX_W     = 5;

  typedef logic [CLK_DIV_CNT_W-1:0] half_t;

  typedef struct packed {
    logic [CLK_DIV_CH_IDX_W-1:0] ch;
    half_t                       half;
  } load_req_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/shadow divisor, square wave and TC strobe.
// A shadow divisor is only copied to the active divisor at a period boundary or while idle.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W        = CLK_DIV_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLK_DIV_DEFAULT_HALF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             load_we,
  input  logic [CNT_W-1:0] load_half,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             tc;
  logic             apply;

  assign tc = (cnt_q == half_q - CNT_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    half_d    = half_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    apply     = 1'b0;

    if (restart || !en) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      apply     = 1'b1;
    end else if (tc) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      apply     = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (apply && pending_q) begin
      half_d    = shadow_q;
      pending_d = 1'b0;
    end

    // Only accepted while nothing is pending, so it never collides with the apply above.
    if (load_we) begin
      shadow_d  = (load_half == '0) ? CNT_W'(1) : load_half;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      half_q    <= DEFAULT_HALF;
      shadow_q  <= DEFAULT_HALF;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pending_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: shared load port decode plus NUM_CH channels.
// Define CLK_DIV_SYNC_EN to add the sync_restart input that phase-aligns all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH       = 4,
  parameter int unsigned      CNT_W        = CLK_DIV_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLK_DIV_DEFAULT_HALF),
  localparam int unsigned     CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_half,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_restart,
`endif
  output logic              load_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CLK_DIV_CH_IDX_W-1:0] ch_idx;
  logic                        ch_ok;
  logic                        sel_pending;
  logic [NUM_CH-1:0]           pending;
  logic [NUM_CH-1:0]           load_we;
  logic                        restart;

`ifdef CLK_DIV_SYNC_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  assign ch_idx = CLK_DIV_CH_IDX_W'(load_ch);
  assign ch_ok  = (ch_idx < CLK_DIV_CH_IDX_W'(NUM_CH));

  always_comb begin
    sel_pending = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CLK_DIV_CH_IDX_W'(i)) begin
        sel_pending = pending[i];
      end
    end
  end

  // Out-of-range channel indices are never ready, so they can never transfer.
  assign load_ready = ch_ok && !sel_pending;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    assign load_we[g] = load_valid && load_ready && (ch_idx == CLK_DIV_CH_IDX_W'(g));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (en[g]),
      .restart   (restart),
      .load_we   (load_we[g]),
      .load_half (load_half),
      .pending   (pending[g]),
      .clk_out   (clk_out[g]),
      .tick      (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with NUM_CH=2, DEFAULT_HALF=4.
// Define CLK_DIV_SYNC_EN to also exercise sync_restart.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en;
  logic       load_valid;
  logic [0:0] load_ch;
  logic [7:0] load_half;
  logic       load_ready;
  logic [1:0] clk_out;
  logic [1:0] tick;
`ifdef CLK_DIV_SYNC_EN
  logic       sync_restart;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH       (2),
    .CNT_W        (8),
    .DEFAULT_HALF (8'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .load_valid   (load_valid),
    .load_ch      (load_ch),
    .load_half    (load_half),
`ifdef CLK_DIV_SYNC_EN
    .sync_restart (sync_restart),
`endif
    .load_ready   (load_ready),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 2'b00; load_valid = 1'b0; load_ch = 1'b0; load_half = 8'd0;
`ifdef CLK_DIV_SYNC_EN
    sync_restart = 1'b0;
`endif
    step(); step();
    chk("rst_clk_out", 8'(clk_out), 8'h00);
    chk("rst_tick", 8'(tick), 8'h00);
    chk("rst_ready", 8'(load_ready), 8'h01);

    // Free run at the default half-period of 4.
    reset = 1'b0; en = 2'b11;
    step(); step(); step();
    chk("run_pre_toggle", 8'(clk_out), 8'h00);
    step();
    chk("run_toggle1_clk", 8'(clk_out), 8'h03);
    chk("run_toggle1_tick", 8'(tick), 8'h03);
    step();
    chk("run_tick_one_cycle", 8'(tick), 8'h00);
    step(); step(); step();
    chk("run_toggle2_clk", 8'(clk_out), 8'h00);
    chk("run_toggle2_tick", 8'(tick), 8'h03);

    // Load ch1 half=2 at the start of a period; applied only at the next TC.
    load_valid = 1'b1; load_ch = 1'b1; load_half = 8'd2;
    #1 chk("ld_ready_before", 8'(load_ready), 8'h01);
    step();
    load_valid = 1'b0;
    chk("ld_ready_ch1_busy", 8'(load_ready), 8'h00);
    load_ch = 1'b0;
    #1 chk("ld_ready_ch0_free", 8'(load_ready), 8'h01);
    step(); step(); step();
    chk("ld_old_half_clk", 8'(clk_out), 8'h03);
    chk("ld_old_half_tick", 8'(tick), 8'h03);
    load_ch = 1'b1;
    #1 chk("ld_ready_after_apply", 8'(load_ready), 8'h01);
    step();
    chk("ld_p13_clk", 8'(clk_out), 8'h03);
    chk("ld_p13_tick", 8'(tick), 8'h00);
    step();
    chk("ld_new_half_clk", 8'(clk_out), 8'h01);
    chk("ld_new_half_tick", 8'(tick), 8'h02);
    step();
    chk("ld_p15_clk", 8'(clk_out), 8'h01);
    step();
    chk("ld_both_tc_clk", 8'(clk_out), 8'h02);
    chk("ld_both_tc_tick", 8'(tick), 8'h03);

    // half=0 clamps to 1; a second request waits until the pending load is applied.
    load_valid = 1'b1; load_ch = 1'b1; load_half = 8'd0;
    step();
    load_half = 8'd3;
    #1 chk("held_ready", 8'(load_ready), 8'h00);
    step();
    chk("clamp_clk_a", 8'(clk_out[1]), 8'h00);
    chk("clamp_tick_a", 8'(tick[1]), 8'h01);
    chk("held_ready_after_tc", 8'(load_ready), 8'h01);
    step();
    load_valid = 1'b0;
    chk("clamp_clk_b", 8'(clk_out[1]), 8'h01);
    chk("clamp_tick_b", 8'(tick[1]), 8'h01);
    chk("held_accepted", 8'(load_ready), 8'h00);
    step();
    chk("clamp_clk_c", 8'(clk_out[1]), 8'h00);
    chk("clamp_tick_c", 8'(tick[1]), 8'h01);
    chk("held_applied", 8'(load_ready), 8'h01);
    step();
    chk("half3_tick_low", 8'(tick[1]), 8'h00);
    step(); step();
    chk("half3_clk", 8'(clk_out[1]), 8'h01);
    chk("half3_tick", 8'(tick[1]), 8'h01);

    // Load while disabled is applied the following cycle.
    en = 2'b00; load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd2;
    step();
    load_valid = 1'b0;
    chk("dis_clk", 8'(clk_out), 8'h00);
    chk("dis_tick", 8'(tick), 8'h00);
    chk("dis_pending", 8'(load_ready), 8'h00);
    step();
    chk("dis_applied", 8'(load_ready), 8'h01);
    en = 2'b01;
    step();
    chk("reen_pre", 8'(clk_out), 8'h00);
    step();
    chk("reen_clk", 8'(clk_out), 8'h01);
    chk("reen_tick", 8'(tick), 8'h01);

    // Reset with a load pending: load discarded, default half restored.
    load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd6;
    step();
    load_valid = 1'b0;
    chk("rstmid_pending", 8'(load_ready), 8'h00);
    reset = 1'b1;
    step();
    chk("rstmid_ready", 8'(load_ready), 8'h01);
    chk("rstmid_clk", 8'(clk_out), 8'h00);
    reset = 1'b0; en = 2'b11;
    step(); step(); step();
    chk("rstmid_pre", 8'(clk_out), 8'h00);
    step();
    chk("rstmid_default_clk", 8'(clk_out), 8'h03);
    chk("rstmid_default_tick", 8'(tick), 8'h03);

`ifdef CLK_DIV_SYNC_EN
    en = 2'b00; load_valid = 1'b1; load_ch = 1'b0; load_half = 8'd3;
    step();
    load_ch = 1'b1; load_half = 8'd5;
    step();
    load_valid = 1'b0;
    step();
    en = 2'b11;
    repeat (7) step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("sync_clk", 8'(clk_out), 8'h00);
    chk("sync_tick", 8'(tick), 8'h00);
    step(); step();
    chk("sync_pre", 8'(clk_out), 8'h00);
    step();
    chk("sync_ch0_clk", 8'(clk_out), 8'h01);
    chk("sync_ch0_tick", 8'(tick), 8'h01);
    step(); step();
    chk("sync_ch1_clk", 8'(clk_out), 8'h03);
    chk("sync_ch1_tick", 8'(tick), 8'h02);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
